// File: rtl/axi_read_engine.sv
// AXI4 burst read engine: splits a byte-length read into INCR bursts that never cross 4 KB,
// keeps a bounded number of ARs in flight and streams every accepted R beat into a FIFO.
module axi_read_engine #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_busy,
    output logic                  o_read_done,
    output logic                  o_cfg_error,
    output logic                  o_resp_error,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_push,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [1:0]            dbg_state
);

    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam int         BSH    = $clog2(BYTES);
    localparam logic [8:0] MAX_N  = 9'(MAX_BURST_BEATS);
    localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [31:0]           ar_beats_left, ar_beats_after, r_beats_left;
    logic [2:0]            outstanding, outstanding_next;
    logic                  arvalid, cfg_err, resp_err;
    logic [12:0]           room_beats, n_bytes;
    logic [8:0]            cap_beats, n_beats;
    logic                  ar_hs, r_hs, rlast_hs, misaligned;

    // Handshakes: a transfer happens on a rising edge where valid && ready; once
    // ARVALID is raised, ARADDR/ARLEN come from registers that only move on that edge.
    assign ar_hs    = arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign rlast_hs = r_hs && m_axi_rlast;

    assign misaligned = (i_src_addr[BSH-1:0] != '0) || (i_total_len[BSH-1:0] != '0);

    // Burst size: remaining beats, capped by the burst limit and the room left in the 4 KB page.
    always_comb begin
        room_beats       = (13'd4096 - {1'b0, ar_addr[11:0]}) >> BSH;
        cap_beats        = (ar_beats_left > 32'(MAX_BURST_BEATS)) ? MAX_N : ar_beats_left[8:0];
        n_beats          = ({4'd0, cap_beats} > room_beats) ? room_beats[8:0] : cap_beats;
        n_bytes          = {4'd0, n_beats} << BSH;
        ar_beats_after   = ar_hs ? (ar_beats_left - {23'd0, n_beats}) : ar_beats_left;
        outstanding_next = outstanding + 3'(ar_hs) - 3'(rlast_hs);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = ((i_total_len == 32'd0) || misaligned) ? DONE : ACTIVE;
            ACTIVE:  if (r_hs && (r_beats_left == 32'd1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_addr       <= '0;
            ar_beats_left <= '0;
            r_beats_left  <= '0;
            outstanding   <= '0;
            arvalid       <= 1'b0;
            cfg_err       <= 1'b0;
            resp_err      <= 1'b0;
        end else if (state == IDLE) begin
            if (i_start) begin
                ar_addr       <= i_src_addr;
                ar_beats_left <= i_total_len >> BSH;
                r_beats_left  <= i_total_len >> BSH;
                outstanding   <= '0;
                resp_err      <= 1'b0;
                cfg_err       <= (i_total_len != 32'd0) && misaligned;
                arvalid       <= (state_next == ACTIVE);
            end
        end else if (state == ACTIVE) begin
            if (ar_hs) begin
                ar_addr       <= ar_addr + ADDR_WIDTH'(n_bytes);
                ar_beats_left <= ar_beats_after;
            end
            outstanding <= outstanding_next;
            if (r_hs) r_beats_left <= r_beats_left - 32'd1;
            if (r_hs && (m_axi_rresp != 2'b00)) resp_err <= 1'b1;
            // A held request may only be replaced once it has been accepted.
            if (!arvalid || ar_hs)
                arvalid <= (ar_beats_after != 32'd0) && (outstanding_next < MAX_OS);
        end else begin
            arvalid <= 1'b0;
        end
    end

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'(BSH);
    assign m_axi_arburst = 2'b01;
    assign m_axi_araddr  = ar_addr;
    assign m_axi_arlen   = arvalid ? 8'(n_beats - 9'd1) : 8'd0;
    assign m_axi_arvalid = arvalid;
    assign m_axi_rready  = (state == ACTIVE) && !i_fifo_full;
    assign o_fifo_push   = r_hs;
    assign o_r_data      = m_axi_rdata;
    assign o_busy        = (state == ACTIVE);
    assign o_read_done   = (state == DONE);
    assign o_cfg_error   = (state == DONE) && cfg_err;
    assign o_resp_error  = resp_err;
    assign dbg_state     = state;

endmodule

// File: tb/tb_axi_read_engine.sv
// Bench for axi_read_engine: randomized AXI slave, burst/data reference model built from
// the byte-level request, and directed scenarios for boundaries, limits, errors and reset.
module tb_axi_read_engine;

    localparam int MAX_OS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_src_addr = '0;
    logic [31:0] i_total_len = '0;
    logic        i_fifo_full = 1'b0;
    logic        o_busy, o_read_done, o_cfg_error, o_resp_error, o_fifo_push;
    logic [31:0] o_r_data;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_rready;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic [1:0]  dbg_state;

    axi_read_engine dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_src_addr(i_src_addr),
        .i_total_len(i_total_len), .o_busy(o_busy), .o_read_done(o_read_done),
        .o_cfg_error(o_cfg_error), .o_resp_error(o_resp_error), .i_fifo_full(i_fifo_full),
        .o_fifo_push(o_fifo_push), .o_r_data(o_r_data), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    logic [39:0] exp_ar_q[$];
    logic [31:0] salt = 32'h1234_5678;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          ar_pct = 100;
    int          r_pct = 100;
    bit          r_hold = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic build_expect(input logic [31:0] a, input logic [31:0] l, output int nars);
        int beats, n, room;
        logic [31:0] cur;
        beats = int'(l / 4);
        cur   = a;
        nars  = 0;
        for (int i = 0; i < beats; i++) exp_q.push_back(pat(a + 32'(4 * i)));
        while (beats > 0) begin
            room = (4096 - int'(cur % 4096)) / 4;
            n = beats;
            if (n > 16) n = 16;
            if (n > room) n = room;
            exp_ar_q.push_back({cur, 8'(n - 1)});
            cur = cur + 32'(n * 4);
            beats -= n;
            nars++;
        end
    endtask

    // ---------------- monitor / scoreboard (samples on negedge) ----------------
    bit          ar_hs_s, r_hs_s, ar_stall;
    logic [31:0] hs_addr_s, stall_addr;
    logic [7:0]  hs_len_s, stall_len;
    int          mdl_out = 0;
    int          ar_total = 0;
    int          push_total = 0;
    int          last_push_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            ar_hs_s  = 1'b0;
            r_hs_s   = 1'b0;
            ar_stall = 1'b0;
            mdl_out  = 0;
        end else begin
            ar_hs_s   = m_axi_arvalid && m_axi_arready;
            r_hs_s    = m_axi_rvalid && m_axi_rready;
            hs_addr_s = m_axi_araddr;
            hs_len_s  = m_axi_arlen;
            if (ar_stall) begin
                check("ar_hold_valid", m_axi_arvalid, 1'b1);
                check("ar_hold_req", {m_axi_araddr, m_axi_arlen}, {stall_addr, stall_len});
            end
            ar_stall   = m_axi_arvalid && !m_axi_arready;
            stall_addr = m_axi_araddr;
            stall_len  = m_axi_arlen;
            if (ar_hs_s) begin
                ar_total++;
                check("ar_outstanding_limit", mdl_out < MAX_OS, 1'b1);
                if (exp_ar_q.size() == 0) check("ar_extra", exp_ar_q.size(), 1);
                else check("ar_req", {m_axi_araddr, m_axi_arlen}, exp_ar_q.pop_front());
            end
            check("push_strobe", o_fifo_push, r_hs_s);
            if (o_fifo_push) begin
                push_total++;
                last_push_cyc = cyc;
                if (exp_q.size() == 0) check("push_extra", exp_q.size(), 1);
                else check("push_data", o_r_data, exp_q.pop_front());
            end
            mdl_out = mdl_out + int'(ar_hs_s) - int'(r_hs_s && m_axi_rlast);
        end
    end

    // ---------------- AXI slave (drives #1 after posedge) ----------------
    logic [31:0] sq_addr[$];
    int          sq_len[$];
    int          beat = 0;
    logic [31:0] ba;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            sq_addr.delete();
            sq_len.delete();
            beat          = 0;
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'b00;
            m_axi_rdata   = '0;
        end else begin
            if (ar_hs_s) begin
                sq_addr.push_back(hs_addr_s);
                sq_len.push_back(int'(hs_len_s));
            end
            if (r_hs_s && sq_addr.size() != 0) begin
                if (beat == sq_len[0]) begin
                    void'(sq_addr.pop_front());
                    void'(sq_len.pop_front());
                    beat = 0;
                end else beat++;
            end
            m_axi_arready = (int'($urandom_range(99)) < ar_pct);
            if (!(m_axi_rvalid && !r_hs_s)) begin
                if (sq_addr.size() != 0 && !r_hold && int'($urandom_range(99)) < r_pct) begin
                    ba           = sq_addr[0] + 32'(4 * beat);
                    m_axi_rdata  = pat(ba);
                    m_axi_rlast  = (beat == sq_len[0]);
                    m_axi_rresp  = (ba == err_addr) ? 2'b10 : 2'b00;
                    m_axi_rvalid = 1'b1;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_src_addr  = a;
        i_total_len = l;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_pushes(input int base, input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (push_total - base >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("push_progress", ok, 1'b1);
    endtask

    // mode: 0 plain, 1 ignored start mid-transfer, 2 outstanding hold, 3 fifo back-pressure
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] l, input bit exp_err, input int mode);
        int nars, base_push, base_ar, done_cyc;
        bit done_ok = 1'b0;
        base_push = push_total;
        base_ar   = ar_total;
        build_expect(a, l, nars);
        if (mode == 2) r_hold = 1'b1;
        do_start(a, l);
        check("busy_after_start", o_busy, 1'b1);
        check("arvalid_after_start", m_axi_arvalid, 1'b1);
        check("resp_err_cleared", o_resp_error, 1'b0);
        if (mode == 1) begin
            wait_pushes(base_push, 3);
            @(posedge clk); #1;
            i_start = 1'b1; i_src_addr = 32'h0000_2000; i_total_len = 32'd64;
            @(posedge clk); #1;
            i_start = 1'b0;
        end else if (mode == 2) begin
            repeat (12) @(negedge clk);
            check("os_ar_count", ar_total - base_ar, 2);
            check("os_arvalid_low", m_axi_arvalid, 1'b0);
            r_hold = 1'b0;
        end else if (mode == 3) begin
            wait_pushes(base_push, 5);
            @(posedge clk); #1;
            i_fifo_full = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("bp_rready_low", m_axi_rready, 1'b0);
                check("bp_no_push", o_fifo_push, 1'b0);
            end
            @(posedge clk); #1;
            i_fifo_full = 1'b0;
        end
        done_cyc = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (o_read_done) begin done_ok = 1'b1; done_cyc = cyc; break; end
        end
        check("done_seen", done_ok, 1'b1);
        check("done_latency", done_cyc - last_push_cyc, 1);
        check("done_cfg_err", o_cfg_error, 1'b0);
        check("resp_err_flag", o_resp_error, exp_err);
        @(negedge clk);
        check("done_one_cycle", o_read_done, 1'b0);
        check("idle_after_done", o_busy, 1'b0);
        check("push_count", push_total - base_push, int'(l / 4));
        check("ar_count", ar_total - base_ar, nars);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_ar_drained", exp_ar_q.size(), 0);
        if (mode == 1) begin
            repeat (5) @(negedge clk);
            check("ignored_start_no_ar", ar_total - base_ar, nars);
            check("ignored_start_idle", m_axi_arvalid, 1'b0);
        end
    endtask

    task automatic run_degen(input logic [31:0] a, input logic [31:0] l, input bit exp_cfg);
        int base_ar = ar_total;
        do_start(a, l);
        check("degen_busy", o_busy, 1'b0);
        check("degen_done", o_read_done, 1'b1);
        check("degen_cfg_err", o_cfg_error, exp_cfg);
        check("degen_arvalid", m_axi_arvalid, 1'b0);
        @(posedge clk); #1;
        check("degen_done_low", o_read_done, 1'b0);
        check("degen_cfg_low", o_cfg_error, 1'b0);
        repeat (3) @(negedge clk);
        check("degen_no_ar", ar_total - base_ar, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a, l;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_read_done, 1'b0);
        check("rst_cfg_err", o_cfg_error, 1'b0);
        check("rst_resp_err", o_resp_error, 1'b0);
        check("rst_push", o_fifo_push, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'd0);
        check("rst_arlen", m_axi_arlen, 8'd0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_arid", m_axi_arid, 1'b0);
        check("rst_arsize", m_axi_arsize, 3'd2);
        check("rst_arburst", m_axi_arburst, 2'b01);
        check("rst_state", dbg_state, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 reset = 1'b0;

        // aligned multi-burst, then the 4 KB crossing
        run_xfer(32'h0000_1000, 32'd256, 1'b0, 0);
        ar_pct = 60; r_pct = 70;
        run_xfer(32'h0000_0FF8, 32'd32, 1'b0, 0);

        // outstanding limit with R held off
        ar_pct = 100; r_pct = 100;
        run_xfer(32'h0000_0000, 32'd256, 1'b0, 2);

        // back-pressure and ignored start
        r_pct = 80;
        run_xfer(32'h0000_4000, 32'd256, 1'b0, 3);
        run_xfer(32'h0000_5000, 32'd128, 1'b0, 1);

        // degenerate requests
        run_degen(32'h0000_1000, 32'd0, 1'b0);
        run_degen(32'h0000_1002, 32'd16, 1'b1);
        run_degen(32'h0000_1000, 32'd18, 1'b1);

        // SLVERR on beat 3; the following start clears the flag
        salt = 32'hCAFE_0001;
        err_addr = 32'h0000_6000 + 32'd12;
        run_xfer(32'h0000_6000, 32'd64, 1'b1, 0);
        err_addr = 32'hFFFF_FFFF;
        run_xfer(32'h0000_6100, 32'd48, 1'b0, 0);

        // reset mid-burst
        err_addr = 32'h0000_3000 + 32'd8;
        begin
            int nars, base_push;
            base_push = push_total;
            build_expect(32'h0000_3000, 32'd256, nars);
            do_start(32'h0000_3000, 32'd256);
            wait_pushes(base_push, 10);
            check("resp_err_before_reset", o_resp_error, 1'b1);
            @(negedge clk); #3;
            reset = 1'b1;
            #1;
            check("mid_rst_busy", o_busy, 1'b0);
            check("mid_rst_resp_err", o_resp_error, 1'b0);
            check("mid_rst_push", o_fifo_push, 1'b0);
            check("mid_rst_arvalid", m_axi_arvalid, 1'b0);
            check("mid_rst_araddr", m_axi_araddr, 32'd0);
            check("mid_rst_rready", m_axi_rready, 1'b0);
            check("mid_rst_state", dbg_state, 2'd0);
            exp_q.delete();
            exp_ar_q.delete();
            err_addr = 32'hFFFF_FFFF;
            repeat (2) @(posedge clk);
            @(negedge clk); #2 reset = 1'b0;
            @(negedge clk);
            check("post_rst_idle", o_busy, 1'b0);
            check("post_rst_arvalid", m_axi_arvalid, 1'b0);
        end
        run_xfer(32'h0000_3000, 32'd64, 1'b0, 0);

        // randomized transfers, biased toward 4 KB page ends
        for (int t = 0; t < 6; t++) begin
            salt   = $urandom;
            a      = 32'($urandom_range(1, 15)) * 32'd4096 - 32'(4 * $urandom_range(0, 40));
            l      = 32'(4 * $urandom_range(1, 80));
            ar_pct = int'($urandom_range(30, 100));
            r_pct  = int'($urandom_range(30, 100));
            run_xfer(a, l, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
